// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
//   Register-file scheduler for the pipelined RV32 core. It keeps a scoreboard
//   of registers waiting on long-latency (load/mul/div) results and stalls
//   decode on RAW/WAW hazards against them. It also arbitrates the single
//   register-file write port between the ALU and the long unit. The long unit
//   is forced to win after STARVE_LIMIT consecutive denied cycles.
//
// Optional feature: define REGFILE_WB_SCHED_BYPASS_EN to let a consumer issue
//   in the same cycle as its producer's long-unit writeback. The value is
//   readable after the negedge register-file write. The same macro lets a
//   long op issue into a full window when a long grant frees a slot that
//   cycle.
//
// Ports
//   clk_i, rst_ni                         clock, async active-low reset
//   id_valid_i, id_rs1_i, id_rs2_i,
//   id_rd_i, id_rd_en_i, id_long_i        decode-stage instruction
//   id_stall_o                            decode must hold this cycle
//   alu_wb_valid_i/addr_i/data_i          ALU writeback
//   alu_wb_stall_o                        ALU writeback denied
//   lu_wb_valid_i/addr_i/data_i           long-unit writeback request
//   lu_wb_ready_o                         long-unit request accepted
//   rf_rd_addr_o/data_o/wren_o            register-file write port
//   busy_o                                scoreboard (bit 0 always 0)
//   outstanding_o                         long ops in flight
module regfile_wb_sched #(
   parameter int STARVE_LIMIT    = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        id_valid_i,
   input  logic [4:0]  id_rs1_i,
   input  logic [4:0]  id_rs2_i,
   input  logic [4:0]  id_rd_i,
   input  logic        id_rd_en_i,
   input  logic        id_long_i,
   output logic        id_stall_o,
   input  logic        alu_wb_valid_i,
   input  logic [4:0]  alu_wb_addr_i,
   input  logic [31:0] alu_wb_data_i,
   output logic        alu_wb_stall_o,
   input  logic        lu_wb_valid_i,
   input  logic [4:0]  lu_wb_addr_i,
   input  logic [31:0] lu_wb_data_i,
   output logic        lu_wb_ready_o,
   output logic [4:0]  rf_rd_addr_o,
   output logic [31:0] rf_rd_data_o,
   output logic        rf_rd_wren_o,
   output logic [31:0] busy_o,
   output logic [4:0]  outstanding_o
);

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
   localparam logic [4:0] OUT_MAX    = 5'(MAX_OUTSTANDING);

   logic [31:0] busy_q, busy_d;
   logic [4:0]  outst_q, outst_d;
   logic [3:0]  wait_q, wait_d;

   logic        long_grant, alu_grant, forced;
   logic        issue, long_issue, full_stall;
   logic [31:0] busy_eff, set_vec, clr_vec;

   always_comb begin
      forced     = (wait_q == STARVE_MAX);
      // Outputs are held at 0 while reset is asserted, not just the state.
      long_grant = rst_ni && lu_wb_valid_i && (forced || !alu_wb_valid_i);
      alu_grant  = rst_ni && alu_wb_valid_i && !long_grant;

      clr_vec = '0;
      if (long_grant && lu_wb_addr_i != 5'd0) clr_vec[lu_wb_addr_i] = 1'b1;

`ifdef REGFILE_WB_SCHED_BYPASS_EN
      busy_eff   = busy_q & ~clr_vec;
      full_stall = id_long_i && (outst_q == OUT_MAX) && !long_grant;
`else
      busy_eff   = busy_q;
      full_stall = id_long_i && (outst_q == OUT_MAX);
`endif

      id_stall_o = rst_ni && id_valid_i &&
                   ((id_rs1_i != 5'd0 && busy_eff[id_rs1_i]) ||
                    (id_rs2_i != 5'd0 && busy_eff[id_rs2_i]) ||
                    (id_rd_en_i && id_rd_i != 5'd0 && busy_eff[id_rd_i]) ||
                    full_stall);

      issue      = rst_ni && id_valid_i && !id_stall_o;
      long_issue = issue && id_long_i;

      set_vec = '0;
      if (long_issue && id_rd_en_i && id_rd_i != 5'd0) set_vec[id_rd_i] = 1'b1;

      // Set wins over clear on the same register.
      busy_d    = (busy_q & ~clr_vec) | set_vec;
      busy_d[0] = 1'b0;

      outst_d = outst_q;
      if (long_issue && !long_grant && outst_q != 5'd31)     outst_d = outst_q + 5'd1;
      else if (!long_issue && long_grant && outst_q != 5'd0) outst_d = outst_q - 5'd1;

      if (long_grant || !lu_wb_valid_i) wait_d = 4'd0;
      else if (forced)                  wait_d = wait_q;
      else                              wait_d = wait_q + 4'd1;

      alu_wb_stall_o = rst_ni && alu_wb_valid_i && long_grant;
      lu_wb_ready_o  = long_grant;

      rf_rd_addr_o = 5'd0;
      rf_rd_data_o = 32'd0;
      rf_rd_wren_o = 1'b0;
      if (long_grant) begin
         rf_rd_addr_o = lu_wb_addr_i;
         rf_rd_data_o = lu_wb_data_i;
         rf_rd_wren_o = (lu_wb_addr_i != 5'd0);
      end else if (alu_grant) begin
         rf_rd_addr_o = alu_wb_addr_i;
         rf_rd_data_o = alu_wb_data_i;
         rf_rd_wren_o = (alu_wb_addr_i != 5'd0);
      end

      busy_o        = busy_q;
      outstanding_o = outst_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q  <= '0;
         outst_q <= '0;
         wait_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         outst_q <= outst_d;
         wait_q  <= wait_d;
      end
   end

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        id_valid_i, id_rd_en_i, id_long_i;
   logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
   logic        id_stall_o;
   logic        alu_wb_valid_i;
   logic [4:0]  alu_wb_addr_i;
   logic [31:0] alu_wb_data_i;
   logic        alu_wb_stall_o;
   logic        lu_wb_valid_i;
   logic [4:0]  lu_wb_addr_i;
   logic [31:0] lu_wb_data_i;
   logic        lu_wb_ready_o;
   logic [4:0]  rf_rd_addr_o;
   logic [31:0] rf_rd_data_o;
   logic        rf_rd_wren_o;
   logic [31:0] busy_o;
   logic [4:0]  outstanding_o;

   int checks = 0;
   int errors = 0;

`ifdef REGFILE_WB_SCHED_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   regfile_wb_sched #(.STARVE_LIMIT(4), .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rd_i(id_rd_i), .id_rd_en_i(id_rd_en_i), .id_long_i(id_long_i),
      .id_stall_o(id_stall_o),
      .alu_wb_valid_i(alu_wb_valid_i), .alu_wb_addr_i(alu_wb_addr_i),
      .alu_wb_data_i(alu_wb_data_i), .alu_wb_stall_o(alu_wb_stall_o),
      .lu_wb_valid_i(lu_wb_valid_i), .lu_wb_addr_i(lu_wb_addr_i),
      .lu_wb_data_i(lu_wb_data_i), .lu_wb_ready_o(lu_wb_ready_o),
      .rf_rd_addr_o(rf_rd_addr_o), .rf_rd_data_o(rf_rd_data_o),
      .rf_rd_wren_o(rf_rd_wren_o), .busy_o(busy_o), .outstanding_o(outstanding_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs change and outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic id_set(input logic v, input logic lng, input logic rd_en,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      id_valid_i = v; id_long_i = lng; id_rd_en_i = rd_en;
      id_rd_i = rd; id_rs1_i = rs1; id_rs2_i = rs2;
   endtask

   initial begin
      rst_ni = 1'b0;
      id_set(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      alu_wb_valid_i = 1'b0; alu_wb_addr_i = 5'd0; alu_wb_data_i = 32'd0;
      lu_wb_valid_i  = 1'b0; lu_wb_addr_i  = 5'd0; lu_wb_data_i  = 32'd0;
      #1;
      chk("reset_busy", busy_o, 32'd0);
      chk("reset_outst", 32'(outstanding_o), 32'd0);
      chk("reset_stall", 32'(id_stall_o), 32'd0);
      chk("reset_wren", 32'(rf_rd_wren_o), 32'd0);
      @(negedge clk_i); rst_ni = 1'b1;
      step();

      // RAW on a long result, released by its writeback
      id_set(1'b1, 1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
      #1 chk("raw_long_issue_stall", 32'(id_stall_o), 32'd0);
      step();
      chk("raw_busy5", busy_o, 32'h20);
      chk("raw_outst1", 32'(outstanding_o), 32'd1);
      id_set(1'b1, 1'b0, 1'b1, 5'd8, 5'd5, 5'd0);
      #1 chk("raw_stall_a", 32'(id_stall_o), 32'd1);
      step();
      chk("raw_stall_b", 32'(id_stall_o), 32'd1);
      lu_wb_valid_i = 1'b1; lu_wb_addr_i = 5'd5; lu_wb_data_i = 32'hDEADBEEF;
      #1;
      chk("raw_wb_ready", 32'(lu_wb_ready_o), 32'd1);
      chk("raw_wb_wren", 32'(rf_rd_wren_o), 32'd1);
      chk("raw_wb_addr", 32'(rf_rd_addr_o), 32'd5);
      chk("raw_wb_data", rf_rd_data_o, 32'hDEADBEEF);
      chk("raw_wb_stall", 32'(id_stall_o), BYP ? 32'd0 : 32'd1);
      step();
      lu_wb_valid_i = 1'b0;
      #1;
      chk("raw_busy_clr", busy_o, 32'd0);
      chk("raw_outst0", 32'(outstanding_o), 32'd0);
      chk("raw_stall_after", 32'(id_stall_o), 32'd0);
      step();
      id_set(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

      // Starvation guard: ALU always valid, long unit valid from cycle 0
      alu_wb_valid_i = 1'b1; alu_wb_addr_i = 5'd3; alu_wb_data_i = 32'h11;
      lu_wb_valid_i  = 1'b1; lu_wb_addr_i  = 5'd9; lu_wb_data_i  = 32'h22;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("starve_alu_stall_c%0d", c), 32'(alu_wb_stall_o), 32'd0);
         chk($sformatf("starve_lu_ready_c%0d", c), 32'(lu_wb_ready_o), 32'd0);
         chk($sformatf("starve_addr_c%0d", c), 32'(rf_rd_addr_o), 32'd3);
         step();
      end
      #1;
      chk("starve_c4_alu_stall", 32'(alu_wb_stall_o), 32'd1);
      chk("starve_c4_lu_ready", 32'(lu_wb_ready_o), 32'd1);
      chk("starve_c4_addr", 32'(rf_rd_addr_o), 32'd9);
      chk("starve_c4_data", rf_rd_data_o, 32'h22);
      step();
      lu_wb_valid_i = 1'b0;
      #1;
      chk("starve_c5_alu_stall", 32'(alu_wb_stall_o), 32'd0);
      chk("starve_c5_addr", 32'(rf_rd_addr_o), 32'd3);
      chk("starve_outst_nowrap", 32'(outstanding_o), 32'd0);
      step();
      alu_wb_valid_i = 1'b0;

      // Long op to x0, writeback to x0
      id_set(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
      #1 chk("x0_issue_stall", 32'(id_stall_o), 32'd0);
      step();
      id_set(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("x0_busy", busy_o, 32'd0);
      chk("x0_outst1", 32'(outstanding_o), 32'd1);
      lu_wb_valid_i = 1'b1; lu_wb_addr_i = 5'd0; lu_wb_data_i = 32'h55;
      #1;
      chk("x0_ready", 32'(lu_wb_ready_o), 32'd1);
      chk("x0_wren", 32'(rf_rd_wren_o), 32'd0);
      step();
      lu_wb_valid_i = 1'b0;
      #1;
      chk("x0_outst0", 32'(outstanding_o), 32'd0);
      chk("x0_busy_after", busy_o, 32'd0);

      // WAW against a pending long result
      id_set(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
      step();
      chk("waw_busy7", busy_o, 32'h80);
      id_set(1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 5'd0);
      #1 chk("waw_stall_a", 32'(id_stall_o), 32'd1);
      step();
      chk("waw_stall_b", 32'(id_stall_o), 32'd1);
      lu_wb_valid_i = 1'b1; lu_wb_addr_i = 5'd7; lu_wb_data_i = 32'h77;
      #1 chk("waw_wb_stall", 32'(id_stall_o), BYP ? 32'd0 : 32'd1);
      step();
      lu_wb_valid_i = 1'b0;
      #1;
      chk("waw_busy_clr", busy_o, 32'd0);
      chk("waw_stall_after", 32'(id_stall_o), 32'd0);
      step();
      id_set(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

      // Outstanding limit
      for (int r = 1; r <= 4; r++) begin
         id_set(1'b1, 1'b1, 1'b1, 5'(r), 5'd0, 5'd0);
         #1 chk($sformatf("full_issue_rd%0d", r), 32'(id_stall_o), 32'd0);
         step();
      end
      chk("full_outst4", 32'(outstanding_o), 32'd4);
      chk("full_busy", busy_o, 32'h1E);
      id_set(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0);
      #1 chk("full_5th_stall", 32'(id_stall_o), 32'd1);
      step();
      chk("full_outst_hold", 32'(outstanding_o), 32'd4);
      id_set(1'b1, 1'b0, 1'b1, 5'd6, 5'd0, 5'd0);
      #1 chk("full_nonlong_issue", 32'(id_stall_o), 32'd0);
      step();
      id_set(1'b1, 1'b1, 1'b1, 5'd10, 5'd0, 5'd0);
      lu_wb_valid_i = 1'b1; lu_wb_addr_i = 5'd1; lu_wb_data_i = 32'h01;
      #1 chk("full_wb_stall", 32'(id_stall_o), BYP ? 32'd0 : 32'd1);
      step();
      lu_wb_valid_i = 1'b0;
`ifndef REGFILE_WB_SCHED_BYPASS_EN
      chk("full_mid_outst3", 32'(outstanding_o), 32'd3);
      #1 chk("full_5th_released", 32'(id_stall_o), 32'd0);
      step();
`endif
      id_set(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      #1;
      chk("full_after_outst", 32'(outstanding_o), 32'd4);
      chk("full_after_busy", busy_o, 32'h41C);

      // Drain one to leave 3 outstanding, then reset mid-operation
      lu_wb_valid_i = 1'b1; lu_wb_addr_i = 5'd2; lu_wb_data_i = 32'h02;
      step();
      lu_wb_valid_i = 1'b0;
      #1;
      chk("pre_rst_outst3", 32'(outstanding_o), 32'd3);
      chk("pre_rst_busy", busy_o, 32'h418);
      rst_ni = 1'b0;
      lu_wb_valid_i = 1'b1; lu_wb_addr_i = 5'd3;
      id_set(1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd4);
      #1;
      chk("rst_busy", busy_o, 32'd0);
      chk("rst_outst", 32'(outstanding_o), 32'd0);
      chk("rst_ready", 32'(lu_wb_ready_o), 32'd0);
      chk("rst_wren", 32'(rf_rd_wren_o), 32'd0);
      chk("rst_stall", 32'(id_stall_o), 32'd0);
      lu_wb_valid_i = 1'b0;
      @(negedge clk_i); rst_ni = 1'b1;
      #1 chk("post_rst_issue", 32'(id_stall_o), 32'd0);
      step();
      id_set(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      chk("post_rst_outst", 32'(outstanding_o), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
